serial_bit_comparator: RTL and testbench

Parametrised, multi-cycle bitwise comparator for two WIDTH-bit operands. It processes SLICE bits per clock, LSB slice first, under a start/done handshake, and reports four modes: any-bit-equal, all-bits-equal, unsigned greater-than and unsigned less-than. It also reports the count of equal bit positions. It sits after the combinational compare cells in the datapath and trades latency for area when WIDTH is large.

---
 rtl/serial_bit_comparator_pkg.sv | 23 ++
 rtl/serial_bit_comparator_slice.sv | 32 +++
 rtl/serial_bit_comparator.sv | 166 ++++++++++++++++
 tb/tb_serial_bit_comparator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bit_comparator_pkg.sv
// Shared types for the serial bit comparator: compare modes, FSM states and
// the width helper used for equal-bit counters.
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_ANY_EQ = 2'd0,
        CMP_ALL_EQ = 2'd1,
        CMP_GT     = 2'd2,
        CMP_LT     = 2'd3
    } cmp_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } cmp_state_e;

    // Bits needed to hold a count of 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_bit_comparator_slice.sv
// Combinational compare of one SLICE-wide operand pair: equal-bit popcount,
// any/all equal flags and unsigned magnitude flags.
module cmp_slice
    import cmp_pkg::*;
#(
    parameter int SLICE = 2,
    parameter int PCW   = cnt_width(SLICE)
) (
    input  logic [SLICE-1:0] xs,
    input  logic [SLICE-1:0] ys,
    output logic [PCW-1:0]   eq_pop,
    output logic             any_eq,
    output logic             all_eq,
    output logic             gt,
    output logic             lt
);

    logic [SLICE-1:0] eqv;

    always_comb begin
        eqv    = ~(xs ^ ys);
        eq_pop = '0;
        for (int i = 0; i < SLICE; i++) begin
            eq_pop = eq_pop + PCW'(eqv[i]);
        end
        any_eq = |eqv;
        all_eq = &eqv;
        gt     = (xs > ys);
        lt     = (xs < ys);
    end

endmodule

// File: rtl/serial_bit_comparator.sv
// Multi-cycle bitwise comparator: walks the operands SLICE bits per clock,
// LSB slice first, and reports the selected mode plus the equal-bit count.
module serial_bit_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    output logic                       busy,
    output logic                       done,
    output logic                       result,
    output logic [$clog2(WIDTH+1)-1:0] match_count
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int PCW    = cnt_width(SLICE);

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    cmp_mode_e        mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic             any_q, any_d, all_q, all_d, gt_q, gt_d, lt_q, lt_d;
    logic             result_q, result_d;
    logic [CNT_W-1:0] match_q, match_d;

    logic [SLICE-1:0] xs, ys;
    logic [PCW-1:0]   s_pop;
    logic             s_any, s_all, s_gt, s_lt;
    logic             last_slice;

    function automatic logic pick_result(input cmp_mode_e m, input logic a_any,
                                         input logic a_all, input logic a_gt,
                                         input logic a_lt);
        case (m)
            CMP_ANY_EQ: return a_any;
            CMP_ALL_EQ: return a_all;
            CMP_GT:     return a_gt;
            default:    return a_lt;
        endcase
    endfunction

    // Slice mux: constant part-selects keep every index in range for any NSLICE.
    always_comb begin
        xs = '0;
        ys = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) begin
                xs = x_q[s*SLICE +: SLICE];
                ys = y_q[s*SLICE +: SLICE];
            end
        end
    end

    cmp_slice #(.SLICE(SLICE), .PCW(PCW)) u_slice (
        .xs     (xs),
        .ys     (ys),
        .eq_pop (s_pop),
        .any_eq (s_any),
        .all_eq (s_all),
        .gt     (s_gt),
        .lt     (s_lt)
    );

    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            mode_q   <= CMP_ANY_EQ;
            idx_q    <= '0;
            eq_cnt_q <= '0;
            any_q    <= 1'b0;
            all_q    <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            result_q <= 1'b0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            eq_cnt_q <= eq_cnt_d;
            any_q    <= any_d;
            all_q    <= all_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            result_q <= result_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulators; result/match_count load from the post-update values on DONE entry.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        eq_cnt_d = eq_cnt_q;
        any_d    = any_q;
        all_d    = all_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        result_d = result_q;
        match_d  = match_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d      = x;
                    y_d      = y;
                    mode_d   = cmp_mode_e'(mode);
                    idx_d    = '0;
                    eq_cnt_d = '0;
                    any_d    = 1'b0;
                    all_d    = 1'b1;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                end
            end
            S_RUN: begin
                eq_cnt_d = eq_cnt_q + CNT_W'(s_pop);
                any_d    = any_q | s_any;
                all_d    = all_q & s_all;
                if (!s_all) begin
                    gt_d = s_gt;
                    lt_d = s_lt;
                end
                idx_d = idx_q + IDX_W'(1);
                if (last_slice) begin
                    result_d = pick_result(mode_q, any_d, all_d, gt_d, lt_d);
                    match_d  = eq_cnt_d;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        result      = result_q;
        match_count = match_q;
    end

endmodule

// File: tb/tb_serial_bit_comparator.sv
// Directed bench for serial_bit_comparator: main 16/2 instance plus 2/1 and
// 8/8 instances for the narrow-slice and single-slice configurations.
module tb_serial_bit_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] x = '0, y = '0;
    logic        busy, done, result;
    logic [4:0]  match_count;

    logic        start2 = 1'b0;
    logic [1:0]  mode2 = 2'd0;
    logic [1:0]  x2 = '0, y2 = '0;
    logic        busy2, done2, result2;
    logic [1:0]  match2;

    logic        start8 = 1'b0;
    logic [1:0]  mode8 = 2'd0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        busy8, done8, result8;
    logic [3:0]  match8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_bit_comparator #(.WIDTH(16), .SLICE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .x(x), .y(y),
        .busy(busy), .done(done), .result(result), .match_count(match_count)
    );

    serial_bit_comparator #(.WIDTH(2), .SLICE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .x(x2), .y(y2),
        .busy(busy2), .done(done2), .result(result2), .match_count(match2)
    );

    serial_bit_comparator #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .result(result8), .match_count(match8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference for the sweep configurations.
    task automatic model(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input int w, output logic r, output int cnt);
        cnt = 0;
        for (int i = 0; i < w; i++) if (a[i] == b[i]) cnt++;
        case (m)
            2'd0: r = (cnt != 0);
            2'd1: r = (cnt == w);
            2'd2: r = (a > b);
            default: r = (a < b);
        endcase
    endtask

    task automatic run16(input string tag, input logic [1:0] m, input logic [15:0] a,
                         input logic [15:0] b, input logic er, input int ec);
        int nb;
        bit gd;
        @(negedge clk);
        start = 1'b1; mode = m; x = a; y = b;
        @(negedge clk);
        start = 1'b0;
        nb = 0; gd = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nb++;
            if (done) begin gd = 1; break; end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, nb, 8);
        check({tag, "_done"}, gd, 1);
        check({tag, "_result"}, result, er);
        check({tag, "_count"}, match_count, ec);
        @(negedge clk);
    endtask

    task automatic run2(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
        logic er; int ec; int nb; bit gd;
        model(m, 16'(a), 16'(b), 2, er, ec);
        @(negedge clk);
        start2 = 1'b1; mode2 = m; x2 = a; y2 = b;
        @(negedge clk);
        start2 = 1'b0;
        nb = 0; gd = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy2) nb++;
            if (done2) begin gd = 1; break; end
            @(negedge clk);
        end
        check("w2_busy_cycles", nb, 2);
        check("w2_done", gd, 1);
        check("w2_result", result2, er);
        check("w2_count", match2, ec);
        @(negedge clk);
    endtask

    task automatic run8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        logic er; int ec; int nb; bit gd;
        model(m, 16'(a), 16'(b), 8, er, ec);
        @(negedge clk);
        start8 = 1'b1; mode8 = m; x8 = a; y8 = b;
        @(negedge clk);
        start8 = 1'b0;
        nb = 0; gd = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy8) nb++;
            if (done8) begin gd = 1; break; end
            @(negedge clk);
        end
        check("w8_busy_cycles", nb, 1);
        check("w8_done", gd, 1);
        check("w8_result", result8, er);
        check("w8_count", match8, ec);
        @(negedge clk);
    endtask

    initial begin
        int nd;
        int t0, t1, cyc;
        bit gd;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_count", match_count, 0);
        rst_n = 1'b1;

        run16("alleq_same", 2'd1, 16'hA5A5, 16'hA5A5, 1'b1, 16);

        // Reset held 3 cycles mid-RUN aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; x = 16'h1111; y = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_result", result, 0);
        check("midrun_rst_count", match_count, 0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("midrun_rst_no_activity", nd, 0);

        run16("alleq_lsb_diff", 2'd1, 16'hA5A5, 16'hA5A4, 1'b0, 15);
        run16("anyeq_none", 2'd0, 16'hFFFF, 16'h0000, 1'b0, 0);
        run16("anyeq_one", 2'd0, 16'hFFFF, 16'h0001, 1'b1, 1);
        run16("gt_msb_override", 2'd2, 16'h8000, 16'h7FFF, 1'b1, 0);
        run16("lt_msb_override", 2'd3, 16'h8000, 16'h7FFF, 1'b0, 0);
        run16("lt_small", 2'd3, 16'h0001, 16'h0002, 1'b1, 14);
        run16("gt_small", 2'd2, 16'h0001, 16'h0002, 1'b0, 14);
        run16("gt_equal", 2'd2, 16'h1234, 16'h1234, 1'b0, 16);
        run16("lt_equal", 2'd3, 16'h1234, 16'h1234, 1'b0, 16);

        // Mid-RUN start pulse and operand/mode changes are ignored.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; x = 16'h00FF; y = 16'h00FF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 2'd2; x = 16'hFFFF; y = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        gd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin gd = 1; break; end
            @(negedge clk);
        end
        check("ignore_done", gd, 1);
        check("ignore_result", result, 1);
        check("ignore_count", match_count, 16);
        @(negedge clk);
        check("ignore_no_rerun", busy, 0);

        // start held high: back-to-back compares every NSLICE+2 cycles.
        @(negedge clk);
        start = 1'b1; mode = 2'd2; x = 16'h0003; y = 16'h0002;
        t0 = -1; t1 = -1; cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (t0 < 0) t0 = cyc;
                else begin t1 = cyc; start = 1'b0; break; end
            end
        end
        start = 1'b0;
        check("b2b_first_done", t0, 9);
        check("b2b_period", t1 - t0, 10);
        check("b2b_result", result, 1);
        check("b2b_count", match_count, 15);
        repeat (2) @(negedge clk);
        check("b2b_stops", busy, 0);

        // WIDTH=2, SLICE=1: exhaustive in all modes.
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    run2(2'(m), 2'(a), 2'(b));

        // WIDTH=8, SLICE=8: directed corners then random operands in all modes.
        for (int m = 0; m < 4; m++) begin
            run8(2'(m), 8'h00, 8'h00);
            run8(2'(m), 8'hFF, 8'h00);
            run8(2'(m), 8'h80, 8'h7F);
            run8(2'(m), 8'h3C, 8'h3D);
        end
        for (int i = 0; i < 32; i++)
            run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
